// File: rtl/if_stage_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_fetch_unit
// Purpose  : Instruction fetch stage with IF/ID register; owns the PC, talks to
//            a variable-latency instruction memory and feeds decode.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage_fetch_unit #(
    parameter int                     ADDRESS_LEN     = 32,
    parameter int                     INSTRUCTION_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [ADDRESS_LEN-1:0]     branch_address,
    output logic                       imem_req,
    output logic [ADDRESS_LEN-1:0]     imem_addr,
    input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
    input  logic                       imem_ready,
    output logic [ADDRESS_LEN-1:0]     PC_out,
    output logic [INSTRUCTION_LEN-1:0] instruction_out,
    output logic                       valid_out
);

    localparam logic [1:0] c_FETCH   = 2'd0;
    localparam logic [1:0] c_DISCARD = 2'd1;
    localparam logic [1:0] c_HOLD    = 2'd2;

    logic [1:0]                 r_state;
    logic [ADDRESS_LEN-1:0]     r_pc;
    logic [ADDRESS_LEN-1:0]     r_discard_addr;
    logic [ADDRESS_LEN-1:0]     r_hold_pc;
    logic [INSTRUCTION_LEN-1:0] r_hold_instr;
    logic [ADDRESS_LEN-1:0]     r_pc_out;
    logic [INSTRUCTION_LEN-1:0] r_instr_out;
    logic                       r_valid_out;
    logic [ADDRESS_LEN-1:0]     w_pc_plus4;

    assign w_pc_plus4      = r_pc + ADDRESS_LEN'(4);
    // An abandoned request keeps its original address until memory answers it.
    assign imem_addr       = (r_state == c_DISCARD) ? r_discard_addr : r_pc;
    assign imem_req        = ~rst & (r_state != c_HOLD);
    assign PC_out          = r_pc_out;
    assign instruction_out = r_instr_out;
    assign valid_out       = r_valid_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_FETCH;
            r_pc           <= RESET_PC;
            r_discard_addr <= RESET_PC;
            r_hold_pc      <= '0;
            r_hold_instr   <= '0;
            r_pc_out       <= '0;
            r_instr_out    <= '0;
            r_valid_out    <= 1'b0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (branch_taken) begin
                        r_pc        <= branch_address;
                        r_pc_out    <= '0;
                        r_instr_out <= '0;
                        r_valid_out <= 1'b0;
                        if (!imem_ready) begin
                            r_discard_addr <= r_pc;
                            r_state        <= c_DISCARD;
                        end
                    end else if (imem_ready) begin
                        r_pc <= w_pc_plus4;
                        if (freeze) begin
                            // Decode is stalled: park the word until it can accept it.
                            r_hold_pc    <= w_pc_plus4;
                            r_hold_instr <= imem_rdata;
                            r_state      <= c_HOLD;
                        end else begin
                            r_pc_out    <= w_pc_plus4;
                            r_instr_out <= imem_rdata;
                            r_valid_out <= 1'b1;
                        end
                    end else if (!freeze) begin
                        r_pc_out    <= '0;
                        r_instr_out <= '0;
                        r_valid_out <= 1'b0;
                    end
                end
                c_DISCARD: begin
                    if (branch_taken) begin
                        r_pc <= branch_address;
                    end
                    if (imem_ready) begin
                        r_state <= c_FETCH;
                    end
                    if (branch_taken || !freeze) begin
                        r_pc_out    <= '0;
                        r_instr_out <= '0;
                        r_valid_out <= 1'b0;
                    end
                end
                c_HOLD: begin
                    if (branch_taken) begin
                        r_pc         <= branch_address;
                        r_hold_pc    <= '0;
                        r_hold_instr <= '0;
                        r_pc_out     <= '0;
                        r_instr_out  <= '0;
                        r_valid_out  <= 1'b0;
                        r_state      <= c_FETCH;
                    end else if (!freeze) begin
                        r_pc_out    <= r_hold_pc;
                        r_instr_out <= r_hold_instr;
                        r_valid_out <= 1'b1;
                        r_state     <= c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage_fetch_unit
// Purpose  : Directed self-checking bench for if_stage_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] PC_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int n_total = 0;
    int n_pass  = 0;

    if_stage_fetch_unit #(
        .ADDRESS_LEN     (32),
        .INSTRUCTION_LEN (32),
        .RESET_PC        (32'h0)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    // ROM: each word is its own address scrambled with a fixed pattern.
    assign imem_rdata = imem_addr ^ 32'hA5A5A5A5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic v);
        chk({tag, ".pc"},    PC_out,                  pc);
        chk({tag, ".instr"}, instruction_out,         ins);
        chk({tag, ".valid"}, {31'd0, valid_out},      {31'd0, v});
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
        branch_address = 32'h0; imem_ready = 1'b0;
        step();
        chk_ifid("reset", 32'h0, 32'h0, 1'b0);
        chk("reset.req",  {31'd0, imem_req}, 32'h0);
        chk("reset.addr", imem_addr, 32'h0);

        // 1: streaming fetch with ready tied high
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        chk("t1.req0",  {31'd0, imem_req}, 32'h1);
        chk("t1.addr0", imem_addr, 32'h0);
        step();
        chk_ifid("t1.a", 32'h4, 32'hA5A5A5A5, 1'b1);
        chk("t1.addr4", imem_addr, 32'h4);
        step();
        chk_ifid("t1.b", 32'h8, 32'hA5A5A5A1, 1'b1);
        chk("t1.addr8", imem_addr, 32'h8);
        step();
        chk_ifid("t1.c", 32'hC, 32'hA5A5A5AD, 1'b1);
        step();
        chk_ifid("t1.d", 32'h10, 32'hA5A5A5A9, 1'b1);
        chk("t1.addr16", imem_addr, 32'h10);

        // 2: slow memory, ready every third cycle
        imem_ready = 1'b0;
        step();
        chk_ifid("t2.bub1", 32'h0, 32'h0, 1'b0);
        chk("t2.hold1", imem_addr, 32'h10);
        step();
        chk_ifid("t2.bub2", 32'h0, 32'h0, 1'b0);
        chk("t2.hold2", imem_addr, 32'h10);
        imem_ready = 1'b1;
        step();
        chk_ifid("t2.v", 32'h14, 32'hA5A5A5B5, 1'b1);
        chk("t2.addr", imem_addr, 32'h14);
        imem_ready = 1'b0;
        step();
        chk_ifid("t2.bub3", 32'h0, 32'h0, 1'b0);

        // 3: freeze with ready on its first cycle, fetched word parked in HOLD
        rst = 1'b1;
        step();
        rst = 1'b0; imem_ready = 1'b1;
        step();
        step();
        chk_ifid("t3.pre", 32'h8, 32'hA5A5A5A1, 1'b1);
        freeze = 1'b1;
        step();
        imem_ready = 1'b0;
        chk_ifid("t3.f1", 32'h8, 32'hA5A5A5A1, 1'b1);
        chk("t3.req1", {31'd0, imem_req}, 32'h0);
        step();
        step();
        step();
        chk_ifid("t3.f4", 32'h8, 32'hA5A5A5A1, 1'b1);
        chk("t3.req4", {31'd0, imem_req}, 32'h0);
        freeze = 1'b0;
        step();
        chk_ifid("t3.held", 32'hC, 32'hA5A5A5AD, 1'b1);
        chk("t3.next", imem_addr, 32'hC);
        chk("t3.req",  {31'd0, imem_req}, 32'h1);
        imem_ready = 1'b1;
        step();
        chk_ifid("t3.after", 32'h10, 32'hA5A5A5A9, 1'b1);

        // 4: redirect while a request to 0x20 is outstanding
        step();
        step();
        step();
        step();
        chk_ifid("t4.pre", 32'h20, 32'hA5A5A5A5 ^ 32'h1C, 1'b1);
        chk("t4.addr20", imem_addr, 32'h20);
        imem_ready = 1'b0; branch_taken = 1'b1; branch_address = 32'h100;
        step();
        branch_taken = 1'b0;
        chk_ifid("t4.flush", 32'h0, 32'h0, 1'b0);
        chk("t4.dis1", imem_addr, 32'h20);
        chk("t4.req",  {31'd0, imem_req}, 32'h1);
        step();
        chk("t4.dis2", imem_addr, 32'h20);
        imem_ready = 1'b1;
        step();
        chk_ifid("t4.drop", 32'h0, 32'h0, 1'b0);
        chk("t4.tgt", imem_addr, 32'h100);
        step();
        chk_ifid("t4.first", 32'h104, 32'hA5A5A4A5, 1'b1);

        // 5: branch and freeze together while in HOLD
        freeze = 1'b1;
        step();
        chk_ifid("t5.hold", 32'h104, 32'hA5A5A4A5, 1'b1);
        chk("t5.req", {31'd0, imem_req}, 32'h0);
        branch_taken = 1'b1; branch_address = 32'h200;
        step();
        branch_taken = 1'b0; freeze = 1'b0;
        chk_ifid("t5.flush", 32'h0, 32'h0, 1'b0);
        chk("t5.tgt", imem_addr, 32'h200);
        step();
        chk_ifid("t5.first", 32'h204, 32'hA5A5A7A5, 1'b1);

        // 6: reset during a memory wait, then PC wrap-around
        imem_ready = 1'b0;
        step();
        chk("t6.wait", imem_addr, 32'h204);
        rst = 1'b1;
        step();
        chk_ifid("t6.rst", 32'h0, 32'h0, 1'b0);
        chk("t6.req",  {31'd0, imem_req}, 32'h0);
        chk("t6.addr", imem_addr, 32'h0);
        rst = 1'b0; imem_ready = 1'b1;
        step();
        chk_ifid("t6.restart", 32'h4, 32'hA5A5A5A5, 1'b1);
        branch_taken = 1'b1; branch_address = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk_ifid("t6.brflush", 32'h0, 32'h0, 1'b0);
        chk("t6.top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk_ifid("t6.wrap", 32'h0, 32'h5A5A5A59, 1'b1);
        chk("t6.wrapaddr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
